// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes phase A/B, decodes Gray-code steps into an
// up/down position count, and flags/counts illegal double-bit transitions.
module quad_decoder #(
  parameter int NBITS_POS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 phase_a,
  input  logic                 phase_b,
  input  logic                 enable,
  input  logic                 load,
  input  logic [NBITS_POS-1:0] load_val,
  output logic [NBITS_POS-1:0] position,
  output logic                 dir_up,
  output logic                 step,
  output logic                 err,
  output logic [NBITS_POS-1:0] err_cnt,
  output logic                 armed
);

  typedef enum logic {ARM, RUN} state_t;

  localparam logic [2:0]           ArmLast = 3'(SYNC_STAGES);
  localparam logic [NBITS_POS-1:0] ErrMax  = '1;

  logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
  logic [1:0]             abS, prevAB_q;
  state_t                 state_q;
  logic [2:0]             armCnt_q;
  logic [NBITS_POS-1:0]   position_q, positionD, errCnt_q;
  logic                   dirUp_q, step_q, err_q;
  logic                   isUp, isDown, isIllegal;

  assign abS = {syncA_q[SYNC_STAGES-1], syncB_q[SYNC_STAGES-1]};

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      syncA_q <= '0;
      syncB_q <= '0;
    end else begin
      syncA_q <= {syncA_q[SYNC_STAGES-2:0], phase_a};
      syncB_q <= {syncB_q[SYNC_STAGES-2:0], phase_b};
    end
  end

  // Up order is 00->01->11->10->00; any two-bit change is illegal.
  always_comb begin
    isUp      = 1'b0;
    isDown    = 1'b0;
    isIllegal = 1'b0;
    case ({prevAB_q, abS})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: isUp      = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: isDown    = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: isIllegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    positionD = position_q;
    if (load) begin
      positionD = load_val;
    end else if (state_q == RUN && enable) begin
      if (isUp)        positionD = position_q + NBITS_POS'(1);
      else if (isDown) positionD = position_q - NBITS_POS'(1);
    end
  end

  // ARM waits for the synchronizer to fill, then seeds prevAB without decoding.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= ARM;
      armCnt_q   <= '0;
      prevAB_q   <= 2'b00;
      position_q <= '0;
      dirUp_q    <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      position_q <= positionD;
      case (state_q)
        ARM: begin
          if (armCnt_q == ArmLast) begin
            prevAB_q <= abS;
            state_q  <= RUN;
          end else begin
            armCnt_q <= armCnt_q + 3'd1;
          end
        end
        RUN: begin
          prevAB_q <= abS;
          if (isUp || isDown) begin
            step_q  <= 1'b1;
            dirUp_q <= isUp;
          end
          if (isIllegal) begin
            err_q <= 1'b1;
            if (errCnt_q != ErrMax) errCnt_q <= errCnt_q + NBITS_POS'(1);
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign position = position_q;
  assign dir_up   = dirUp_q;
  assign step     = step_q;
  assign err      = err_q;
  assign err_cnt  = errCnt_q;
  assign armed    = (state_q == RUN);

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter: NBITS_POS, default 4, width of position and error counters.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth on phase inputs (legal range 2..4).
REQ-003 clk_2  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 phase_a  input  1  quadrature channel A, asynchronous to clk_2.
REQ-006 phase_b  input  1  quadrature channel B, asynchronous to clk_2.
REQ-007 enable  input  1  synchronous; 1 = position follows decoded steps.
REQ-008 load  input  1  synchronous; 1 = position loaded from load_val.
REQ-009 load_val  input  NBITS_POS  value loaded into position.
REQ-010 position  output  NBITS_POS  registered up/down position count.
REQ-011 dir_up  output  1  registered; direction of the most recent legal step (1 = up).
REQ-012 step  output  1  registered one-cycle pulse per legal step.
REQ-013 err  output  1  registered one-cycle pulse per illegal transition.
REQ-014 err_cnt  output  NBITS_POS  saturating count of illegal transitions.
REQ-015 armed  output  1  1 when state machine is in RUN.

Function
REQ-016 phase_a/phase_b SHALL each pass through SYNC_STAGES flip-flops; only the last stage (AB_s) is decoded.
REQ-017 The state machine SHALL have states ARM and RUN; ARM counts SYNC_STAGES cycles after reset release, then, on the next edge, loads prev_AB <= AB_s without decoding and enters RUN.
REQ-018 In ARM, step, err, dir_up and err_cnt SHALL not change; load SHALL still be honoured.
REQ-019 In RUN, every edge SHALL decode (prev_AB -> AB_s) and then set prev_AB <= AB_s.
REQ-020 Up sequence (AB): 00->01->11->10->00; down sequence is the reverse.
REQ-021 Legal up step: step=1, dir_up=1, position+1 if enable; legal down step: step=1, dir_up=0, position-1 if enable.
REQ-022 No change (prev_AB == AB_s): step=0, err=0; position and dir_up hold.
REQ-023 Illegal (both bits change): err=1, step=0, position and dir_up hold, err_cnt+1 saturating at 2^NBITS_POS-1.
REQ-024 step and err SHALL be asserted for exactly one cycle per decoded event and never together.
REQ-025 Position SHALL wrap modulo 2^NBITS_POS (max+1 -> 0, 0-1 -> max).
REQ-026 load=1 SHALL set position <= load_val with priority over any step in the same cycle; step/err/dir_up/err_cnt still update per decode.
REQ-027 enable=0 SHALL freeze position only; step, err, dir_up, err_cnt keep updating.
REQ-028 Latency: a phase input edge meeting setup before edge N SHALL appear on position/step/err after edge N+SYNC_STAGES.
REQ-029 Step rate SHALL be at most one per clk_2 cycle; faster input changes appear as illegal or missed transitions by design.

Reset
REQ-030 While reset=1: synchronizer stages, prev_AB = 00, position = 0, dir_up = 0, step = 0, err = 0, err_cnt = 0, state = ARM, arm counter = 0, armed = 0.
REQ-031 reset SHALL act immediately (asynchronously) on assertion, including mid-sequence in RUN; release SHALL restart the ARM sequence.
REQ-032 The first sample after reset release SHALL never produce step or err regardless of phase input levels.

Verification
REQ-033 Reset with AB=11 held, release, wait 5 cycles -> armed=1, step=0, err=0, position=0 throughout.
REQ-034 From RUN at AB=00, drive 01,11,10,00 each held 4 cycles, enable=1 -> position 0->1->2->3->4, four step pulses, dir_up=1.
REQ-035 Position 0, drive one down step (00->10) -> position=15, dir_up=0; then 16 up steps -> position=15 again.
REQ-036 Jump AB 00->11 three times via 00->11->00->11 -> err pulses 3, err_cnt=3, position unchanged; 20 illegal jumps -> err_cnt=15 (saturated).
REQ-037 load=1, load_val=9 in the same cycle a legal up step decodes -> position=9, step=1, dir_up=1; enable=0 with 2 up steps -> position stays 9, two step pulses.
REQ-038 Assert reset mid-sequence with position=6, err_cnt=2 -> all outputs 0 on assertion without waiting for clk_2; after release, ARM repeats per REQ-017.
